// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
//  Package : adder_pkg
//  Brief   : Shared constants and FSM state type for nibble_serial_adder.
//  Rev     : 1.0  initial release
// ============================================================================
package adder_pkg;

    // Width of one carry-lookahead slice in bits.
    localparam int NIBBLE_W = 4;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : adder_pkg
`default_nettype wire

// File: rtl/nibble_serial_adder_cla4_slice.sv
`default_nettype none
// ============================================================================
//  Module  : cla4_slice
//  Brief   : Combinational 4-bit carry-lookahead adder slice using
//            propagate/generate terms. Also exposes the carry into bit 3
//            so the caller can form signed overflow.
//  Rev     : 1.0  initial release
// ============================================================================
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       c3,
    output logic       co
);

    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [4:0] w_c;

    // Flattened lookahead carries; every carry depends only on p/g and ci.
    always_comb begin
        w_p    = a ^ b;
        w_g    = a & b;
        w_c[0] = ci;
        w_c[1] = w_g[0] | (w_p[0] & ci);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & ci);
        w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);
        s      = w_p ^ w_c[3:0];
        c3     = w_c[3];
        co     = w_c[4];
    end

endmodule : cla4_slice
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module  : nibble_serial_adder
//  Brief   : WIDTH-bit adder that walks the operands one nibble per cycle
//            through a single 4-bit CLA slice, keeping the inter-nibble
//            carry in a register. valid/ready on both sides.
//  Rev     : 1.0  initial release
// ============================================================================
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16   // multiple of 4, at least 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   a_q,      a_d;
    logic [WIDTH-1:0]   b_q,      b_d;
    logic               carry_q,  carry_d;
    logic [IDX_W-1:0]   idx_q,    idx_d;
    logic [WIDTH-1:0]   sum_q,    sum_d;
    logic               cout_q,   cout_d;
    logic               ovf_q,    ovf_d;

    logic [3:0]         w_slice_a;
    logic [3:0]         w_slice_b;
    logic [3:0]         w_slice_s;
    logic               w_slice_c3;
    logic               w_slice_co;

    // Present the current nibble of the latched operands to the slice.
    always_comb begin
        w_slice_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
        w_slice_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];
    end

    cla4_slice u_slice (
        .a  (w_slice_a),
        .b  (w_slice_b),
        .ci (carry_q),
        .s  (w_slice_s),
        .c3 (w_slice_c3),
        .co (w_slice_co)
    );

    // Next-state and datapath update for the IDLE -> ADD -> DONE sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = w_slice_s;
                carry_d = w_slice_co;
                if (idx_q == C_LAST_IDX) begin
                    // Overflow from the top nibble: carry into MSB xor carry out.
                    cout_d  = w_slice_co;
                    ovf_d   = w_slice_c3 ^ w_slice_co;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake outputs decode the state; in_ready is masked by reset.
    always_comb begin
        in_ready  = (state_q == ST_IDLE) & ~rst;
        out_valid = (state_q == ST_DONE);
        sum       = sum_q;
        cout      = cout_q;
        overflow  = ovf_q;
    end

endmodule : nibble_serial_adder
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module  : tb_nibble_serial_adder
//  Brief   : Self-checking bench for nibble_serial_adder (WIDTH=16) with an
//            arithmetic reference model and randomized operands.
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_nibble_serial_adder;

    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    int checks   = 0;
    int failures = 0;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Reference: full-width integer add; signed overflow from operand/result signs.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] ma,
                                               input logic [WIDTH-1:0] mb,
                                               input logic mc);
        logic [WIDTH:0] full;
        logic           ovf;
        full = {1'b0, ma} + {1'b0, mb} + {{WIDTH{1'b0}}, mc};
        ovf  = (ma[WIDTH-1] == mb[WIDTH-1]) && (full[WIDTH-1] != ma[WIDTH-1]);
        return {ovf, full};
    endfunction

    // One full transaction: accept, latency check, result check, optional
    // backpressure, output handshake and return to IDLE.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                          input logic tc, input int hold, input bit mid_change,
                          input string name);
        logic [WIDTH+1:0] exp;
        logic [WIDTH-1:0] held_sum;
        int n;
        exp = model(ta, tb_, tc);
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s in_ready_timeout got=%b want=1", name, in_ready);
        end
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);   // accept edge
        #1;
        if (mid_change) begin
            a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
        end else begin
            in_valid = 1'b0;
        end
        // out_valid must appear after the NIBBLES-th edge following accept
        // (NIBBLES+1 edges counting the accept edge itself).
        for (int k = 1; k <= NIBBLES; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== (k == NIBBLES) || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s latency edge=%0d out_valid=%b in_ready=%b want_valid=%b want_ready=0",
                         name, k, out_valid, in_ready, (k == NIBBLES));
            end
            if (mid_change) begin
                a = WIDTH'($urandom); b = WIDTH'($urandom);
                if (k == NIBBLES - 1) in_valid = 1'b0;
            end
        end
        checks++;
        if (sum !== exp[WIDTH-1:0] || cout !== exp[WIDTH] || overflow !== exp[WIDTH+1]) begin
            failures++;
            $display("FAIL %s result got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     name, sum, cout, overflow, exp[WIDTH-1:0], exp[WIDTH], exp[WIDTH+1]);
        end
        held_sum = sum;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom); a = WIDTH'($urandom); b = WIDTH'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== held_sum ||
                cout !== exp[WIDTH] || overflow !== exp[WIDTH+1]) begin
                failures++;
                $display("FAIL %s hold cyc=%0d valid=%b ready=%b sum=%h want valid=1 ready=0 sum=%h",
                         name, h, out_valid, in_ready, sum, held_sum);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);   // output handshake edge
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s release out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_state ready=%b valid=%b sum=%h cout=%b ovf=%b want all 0",
                     in_ready, out_valid, sum, cout, overflow);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        run_op(16'h1234, 16'h4321, 1'b1, 0, 1'b0, "dir_1234");
        run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, "dir_ripple");
        run_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0, "dir_pos_ovf");
        run_op(16'h8000, 16'h8000, 1'b0, 0, 1'b0, "dir_neg_ovf");
    endtask

    task automatic test_backpressure();
        run_op(16'hA5C3, 16'h1F0E, 1'b1, 10, 1'b0, "backpressure");
    endtask

    task automatic test_midop_change();
        run_op(16'h0F0F, 16'h7070, 1'b0, 0, 1'b1, "midop_change");
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);   // accept
        #1 in_valid = 1'b0;
        @(posedge clk);   // first ADD edge writes nibble 0
        #2 rst = 1'b1;
        #1;
        checks++;
        if (sum !== '0 || cout !== 1'b0 || overflow !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_midop_async sum=%h cout=%b ovf=%b valid=%b ready=%b want all 0",
                     sum, cout, overflow, out_valid, in_ready);
        end
        repeat (6) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_midop_no_valid out_valid=%b want 0", out_valid);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(16'h0001, 16'h0001, 1'b0, 0, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom), "random");
        end
    endtask

    // Consecutive operations with in_valid offered as soon as possible.
    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 0, 1'b0, "back_to_back");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_midop_change();
        test_reset_midop();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #200000;
        failures++;
        $display("FAIL global_timeout reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_nibble_serial_adder
`default_nettype wire
